// File: rtl/tri_feed_queue.sv
// tri_feed_queue: triangle FIFO feeding the rasterizer R10 inputs.
// Producer side: in_valid_H/in_ready_H. A push happens on a rising edge with
// in_valid_H=1 and in_ready_H=1. Rasterizer side: validTri_R10H/halt_RnnnnL.
// A pop happens on a rising edge with validTri_R10H=1 and halt_RnnnnL=1.
// Once valid is high, the head data is held until it is popped. All outputs
// come from registered state only.
module tri_feed_queue #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4,
    parameter int CNTW   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [SIGFIG-1:0]          in_tri_S   [VERTS][AXIS],
    input  logic        [SIGFIG-1:0]          in_color_U [COLORS],
    input  logic                              in_valid_H,
    output logic                              in_ready_H,
    input  logic                              flush_H,
    output logic signed [SIGFIG-1:0]          tri_R10S   [VERTS][AXIS],
    output logic        [SIGFIG-1:0]          color_R10U [COLORS],
    output logic                              validTri_R10H,
    input  logic                              halt_RnnnnL,
    output logic [$clog2(DEPTH+1)-1:0]        count_U,
    output logic [CNTW-1:0]                   issued_U
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = VERTS*AXIS*SIGFIG;
    localparam int KW = COLORS*SIGFIG;

    // Entries are stored flattened. Vertex v, axis a sits at slice
    // (v*AXIS+a)*SIGFIG. Color c sits at slice c*SIGFIG.
    logic [TW-1:0] tri_mem   [DEPTH];
    logic [KW-1:0] color_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [TW-1:0] in_tri_flat;
    logic [KW-1:0] in_color_flat;
    logic [TW-1:0] head_tri;
    logic [KW-1:0] head_color;
    logic          push;
    logic          pop;

    // Handshakes use only registered occupancy. A full queue therefore
    // refuses a push even if the head is popped on the same edge.
    assign validTri_R10H = (count_U != '0);
    assign in_ready_H    = (count_U != CW'(DEPTH));
    assign push          = in_valid_H & in_ready_H & ~flush_H;
    assign pop           = validTri_R10H & halt_RnnnnL & ~flush_H;

    // Flatten the producer triangle and color into storage words.
    always_comb begin
        in_tri_flat   = '0;
        in_color_flat = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                in_tri_flat[(v*AXIS+a)*SIGFIG +: SIGFIG] = in_tri_S[v][a];
        for (int c = 0; c < COLORS; c++)
            in_color_flat[c*SIGFIG +: SIGFIG] = in_color_U[c];
    end

    // Storage write. Reset does not clear storage because the pointers
    // already mask stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            tri_mem[wr_ptr]   <= in_tri_flat;
            color_mem[wr_ptr] <= in_color_flat;
        end
    end

    // Pointers, occupancy and issue counter.
    // A flush discards any push or pop on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_U  <= '0;
            issued_U <= '0;
        end else if (flush_H) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_U <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                issued_U <= issued_U + CNTW'(1);
            end
            case ({push, pop})
                2'b10:   count_U <= count_U + CW'(1);
                2'b01:   count_U <= count_U - CW'(1);
                default: count_U <= count_U;
            endcase
        end
    end

    // Present the head entry. When the queue is empty, present zero.
    always_comb begin
        head_tri   = validTri_R10H ? tri_mem[rd_ptr]   : '0;
        head_color = validTri_R10H ? color_mem[rd_ptr] : '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R10S[v][a] = head_tri[(v*AXIS+a)*SIGFIG +: SIGFIG];
        for (int c = 0; c < COLORS; c++)
            color_R10U[c] = head_color[c*SIGFIG +: SIGFIG];
    end

endmodule

// File: tb/tb_tri_feed_queue.sv
// Testbench for tri_feed_queue: randomized and directed stimulus checked
// against a queue-based reference model of the triangle FIFO.
module tb_tri_feed_queue;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int DEPTH  = 4;
    localparam int CNTW   = 16;
    localparam int CW     = $clog2(DEPTH+1);
    localparam int TW     = VERTS*AXIS*SIGFIG;
    localparam int DW     = TW + COLORS*SIGFIG;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [SIGFIG-1:0] in_tri_S   [VERTS][AXIS];
    logic        [SIGFIG-1:0] in_color_U [COLORS];
    logic                     in_valid_H  = 1'b0;
    logic                     in_ready_H;
    logic                     flush_H     = 1'b0;
    logic signed [SIGFIG-1:0] tri_R10S   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R10U [COLORS];
    logic                     validTri_R10H;
    logic                     halt_RnnnnL = 1'b1;
    logic [CW-1:0]            count_U;
    logic [CNTW-1:0]          issued_U;

    tri_feed_queue #(
        .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS),
        .COLORS(COLORS), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_tri_S(in_tri_S), .in_color_U(in_color_U),
        .in_valid_H(in_valid_H), .in_ready_H(in_ready_H),
        .flush_H(flush_H),
        .tri_R10S(tri_R10S), .color_R10U(color_R10U),
        .validTri_R10H(validTri_R10H), .halt_RnnnnL(halt_RnnnnL),
        .count_U(count_U), .issued_U(issued_U)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0]   exp_q[$];
    logic [CNTW-1:0] m_issued = '0;
    int              vectors     = 0;
    int              miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [DW-1:0] out_word();
        logic [DW-1:0] d;
        d = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                d[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_R10S[v][a];
        for (int c = 0; c < COLORS; c++)
            d[TW + c*SIGFIG +: SIGFIG] = color_R10U[c];
        return d;
    endfunction

    task automatic drive_data(input logic [DW-1:0] d);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                in_tri_S[v][a] = d[(v*AXIS+a)*SIGFIG +: SIGFIG];
        for (int c = 0; c < COLORS; c++)
            in_color_U[c] = d[TW + c*SIGFIG +: SIGFIG];
    endtask

    // Model one clock edge from the queue contents before the edge.
    task automatic model_edge(input logic v, input logic h, input logic f, input logic [DW-1:0] d);
        bit can_pop;
        bit can_push;
        can_pop  = (exp_q.size() != 0) && h;
        can_push = v && (exp_q.size() < DEPTH);
        if (f) begin
            exp_q.delete();
        end else begin
            if (can_pop) begin
                void'(exp_q.pop_front());
                m_issued++;
            end
            if (can_push) exp_q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},  DW'(count_U),       DW'(exp_q.size()));
        check({tag, ".ready"},  DW'(in_ready_H),    DW'(exp_q.size() < DEPTH));
        check({tag, ".valid"},  DW'(validTri_R10H), DW'(exp_q.size() != 0));
        check({tag, ".head"},   out_word(),         (exp_q.size() != 0) ? exp_q[0] : '0);
        check({tag, ".issued"}, DW'(issued_U),      DW'(m_issued));
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge. Inputs apply to the next rising
    // edge, and outputs are checked at the following falling edge.
    task automatic step(input logic v, input logic h, input logic f, input logic [DW-1:0] d,
                        input bit chk, input string tag);
        in_valid_H  = v;
        halt_RnnnnL = h;
        flush_H     = f;
        drive_data(d);
        @(posedge clk);
        model_edge(v, h, f, d);
        @(negedge clk);
        if (chk) check_all(tag);
    endtask

    logic [DW-1:0] d1;
    logic [DW-1:0] dz;
    int            guard;

    initial begin
        dz = '0;
        drive_data(dz);

        // Reset state, checked before any clock edge.
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single known triangle: {(1,2,3),(4,5,6),(7,8,9)}, color {10,11,12}.
        d1 = '0;
        for (int i = 0; i < 9; i++) d1[i*SIGFIG +: SIGFIG] = SIGFIG'(i + 1);
        for (int c = 0; c < 3; c++) d1[TW + c*SIGFIG +: SIGFIG] = SIGFIG'(10 + c);
        step(1, 1, 0, d1, 1, "t1_push");
        check("t1_x22",   DW'(tri_R10S[2][2]), DW'(9));
        check("t1_col2",  DW'(color_R10U[2]),  DW'(12));
        step(0, 1, 0, dz, 1, "t1_pop");
        check("t1_issued", DW'(issued_U), DW'(1));

        // Fill with halt low, attempt a 5th push, then drain in order.
        for (int i = 1; i <= 5; i++) step(1, 0, 0, DW'(i), 1, "fill");
        check("full_ready", DW'(in_ready_H), DW'(0));
        for (int i = 0; i < 4; i++) step(0, 1, 0, dz, 1, "drain");
        check("drain_issued", DW'(issued_U), DW'(5));

        // Continuous traffic with halt toggling 1,0,1,0.
        for (int i = 0; i < 40; i++) step(1, (i % 2) == 0, 0, rand_word(), 1, "toggle");

        // Full queue with a push and a pop on the same edge.
        while (exp_q.size() < DEPTH) step(1, 0, 0, rand_word(), 1, "refill");
        step(1, 1, 0, rand_word(), 1, "full_pushpop");
        step(1, 0, 0, rand_word(), 1, "after_full");

        // Three entries queued, then flush with a push and a pop on the same edge.
        while (exp_q.size() != 0) step(0, 1, 0, dz, 1, "empty");
        for (int i = 0; i < 3; i++) step(1, 0, 0, rand_word(), 1, "pre_flush");
        step(1, 1, 1, rand_word(), 1, "flush");

        // Random mix including occasional flushes.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, rand_word(), 1, "rand");

        // Run the issue counter up to its top value, then pop once more so it wraps.
        guard = 0;
        while (m_issued != '1 && guard < 70000) begin
            step(1, 1, 0, rand_word(), 0, "bulk");
            guard++;
        end
        check("bulk_guard", DW'(guard < 70000), DW'(1));
        while (exp_q.size() == 0 && guard < 70010) begin
            step(1, 0, 0, rand_word(), 0, "prime");
            guard++;
        end
        check_all("pre_wrap");
        step(1, 1, 0, rand_word(), 1, "wrap");
        check("wrap_zero", DW'(issued_U), DW'(0));

        // Build up some state, then reset asynchronously between edges.
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 1), 0, rand_word(), 1, "pre_rst");
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        m_issued = '0;
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1, $urandom_range(0, 1), 0, rand_word(), 1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
